caf_peak_finder: RTL and testbench
==================================

# caf_peak_finder

Downstream consumer of the pipelined complex dot-product stage in the CAF datapath. Accepts the stream of complex correlation products (i, q), forms |z|² = i² + q² in a two-stage pipeline, and tracks the maximum over a frame of LENGTH products. At frame end it presents the peak index and magnitude on a valid/ready output. This output drives the CAF delay/Doppler search logic.

## Interface
- I_BITS, 16: signed width of input i; must match the producer's sum_i width.
- Q_BITS, 16: signed width of input q; must match the producer's sum_q width.
- LENGTH, 64: products per frame; must be at least 1.
- INDEX_BITS, 6: width of peak index; must satisfy 2^INDEX_BITS ≥ LENGTH.
- MAG_BITS, 2*max(I_BITS,Q_BITS): width of the unsigned magnitude.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- s_axis_product_tvalid  in  1  input product valid.
- i  in  I_BITS  signed in-phase product.
- q  in  Q_BITS  signed quadrature product.
- m_axis_product_tready  out  1  input ready.
- s_axis_peak_tvalid  out  1  peak result valid.
- m_axis_peak_tready  in  1  downstream accepts result.
- peak_index  out  INDEX_BITS  0-based frame position of the peak.
- peak_mag  out  MAG_BITS  i² + q² at the peak.

## Operation
- Input accept: s_axis_product_tvalid && m_axis_product_tready on a rising edge. Cycles without valid are not counted.
- Magnitude: stage 1 registers i*i and q*q as signed products, each carried as unsigned 2B-1 bits. Stage 2 registers the unsigned sum. No truncation or saturation; (-2^(B-1))² + (-2^(B-1))² fits in MAG_BITS.
- Each pipeline stage carries a valid bit and the sample index from a 0..LENGTH-1 accept counter.
- Tracker: a stage-2 valid result replaces the running max only if strictly greater. Index 0 always loads. Ties keep the earliest index.
- FSM:
  - ACCUM: ready=1. The LENGTH-th accept moves to DRAIN, and the accept counter wraps to 0.
  - DRAIN: ready=0. Waits until both pipeline valids clear, then moves to HOLD, latching the tracker into the output registers.
  - HOLD: ready=0, s_axis_peak_tvalid=1. On m_axis_peak_tready, moves to ACCUM and clears the tracker.
- Outputs peak_index and peak_mag stay stable throughout HOLD.
- A frame of all-zero products reports index 0, mag 0.

## Timing
- Reset values:
  - State ACCUM; counter, pipeline valids, tracker and outputs all 0.
  - s_axis_peak_tvalid=0.
  - m_axis_product_tready=0 while reset is high, and 1 on the first edge after release.
- Latency: if the last sample is accepted at edge n, s_axis_peak_tvalid rises after edge n+3. That is two pipeline stages plus the latch into HOLD.
- m_axis_product_tready falls after the edge of the LENGTH-th accept. No sample of the next frame enters before the result handshake.
- Result handshake at edge h: tvalid falls and ready rises after h. The first sample of the next frame can be accepted at h+1.
- m_axis_peak_tready is ignored outside HOLD. tvalid does not depend combinationally on tready.
- Reset mid-frame or mid-HOLD: immediately returns to the reset values, and any partial frame or pending result is discarded.
- Input valid/data are sampled only on accept, so i and q may change freely while not accepted.

## Structure
- Shared package caf_pkg holds:
  - the state enum (ACCUM, DRAIN, HOLD);
  - a mag_bits(i_bits, q_bits) width function used by this block and the search logic.
- Sub-module cplx_mag_sq: the two-stage i²+q² pipeline with valid and index sideband. It is reusable by other CAF magnitude consumers.
- The FSM, accept counter and tracker live in the top level.

## Test plan
Unless noted, runs use I_BITS=Q_BITS=8 and LENGTH=8.
- Single peak: (3,4) at index 5 and (1,1) elsewhere, valid every cycle -> peak_index=5, peak_mag=25, tvalid 3 cycles after the last accept.
- Tie: (5,5) at indices 2 and 6, (0,0) elsewhere -> peak_index=2, peak_mag=50.
- Extreme: (-128,-128) at index 0, (127,127) elsewhere -> peak_index=0, peak_mag=32768, with no overflow.
- Backpressure: m_axis_peak_tready held low for 10 cycles in HOLD:
  - tvalid, peak_index and peak_mag stay constant;
  - m_axis_product_tready stays 0;
  - after the handshake, ready returns 1 on the next edge.
- Gapped input: valid toggling 1010… with frame (0,0)×7 then (2,0) at index 7 -> only accepted samples count; result is peak_index=7, peak_mag=4.
- Mid-frame reset: reset asserted after 4 accepts -> all outputs go to reset values; the following full frame (3,4) at index 1 reports peak_index=1, peak_mag=25.

Source files
------------

// File: rtl/caf_pkg.sv
// Shared CAF datapath definitions.
// Holds the peak-finder state encoding and the magnitude width helper.
package caf_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } caf_state_e;

    // Unsigned width that holds i^2 + q^2 for the widest operand at full negative scale.
    function automatic int unsigned mag_bits(input int unsigned i_bits, input int unsigned q_bits);
        return 2 * ((i_bits > q_bits) ? i_bits : q_bits);
    endfunction

endpackage

// File: rtl/cplx_mag_sq.sv
// Two-stage |z|^2 = i^2 + q^2 pipeline with valid and index sideband.
// Stage 1 registers the squares, stage 2 registers their unsigned sum.
module cplx_mag_sq
    import caf_pkg::*;
#(
    parameter int unsigned I_BITS     = 16,
    parameter int unsigned Q_BITS     = 16,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned MAG_BITS   = mag_bits(I_BITS, Q_BITS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic signed [I_BITS-1:0]     i,
    input  logic signed [Q_BITS-1:0]     q,
    input  logic        [INDEX_BITS-1:0] in_index,
    output logic                         mid_valid,
    output logic                         out_valid,
    output logic        [INDEX_BITS-1:0] out_index,
    output logic        [MAG_BITS-1:0]   out_mag
);

    localparam int unsigned I_EXT_BITS = 2 * I_BITS;
    localparam int unsigned Q_EXT_BITS = 2 * Q_BITS;
    localparam int unsigned I_SQ_BITS  = 2 * I_BITS - 1;
    localparam int unsigned Q_SQ_BITS  = 2 * Q_BITS - 1;

    logic signed [I_EXT_BITS-1:0] i_ext_c;
    logic signed [Q_EXT_BITS-1:0] q_ext_c;
    logic signed [I_EXT_BITS-1:0] i_prod_c;
    logic signed [Q_EXT_BITS-1:0] q_prod_c;

    logic [INDEX_BITS-1:0] mid_index;
    logic [I_SQ_BITS-1:0]  i_sq;
    logic [Q_SQ_BITS-1:0]  q_sq;

    // A square is never negative, so the sign bit of the full product is always zero.
    always_comb begin
        i_ext_c  = I_EXT_BITS'(i);
        q_ext_c  = Q_EXT_BITS'(q);
        i_prod_c = i_ext_c * i_ext_c;
        q_prod_c = q_ext_c * q_ext_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mid_valid <= 1'b0;
            mid_index <= '0;
            i_sq      <= '0;
            q_sq      <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_mag   <= '0;
        end else begin
            mid_valid <= in_valid;
            if (in_valid) begin
                mid_index <= in_index;
                i_sq      <= I_SQ_BITS'(i_prod_c);
                q_sq      <= Q_SQ_BITS'(q_prod_c);
            end
            out_valid <= mid_valid;
            if (mid_valid) begin
                out_index <= mid_index;
                out_mag   <= MAG_BITS'(i_sq) + MAG_BITS'(q_sq);
            end
        end
    end

endmodule

// File: rtl/caf_peak_finder.sv
// Frame-based peak search over |z|^2 of complex correlation products.
// Accepts LENGTH products, drains the pipeline, then holds the peak until handshaken.
module caf_peak_finder
    import caf_pkg::*;
#(
    parameter int unsigned I_BITS     = 16,
    parameter int unsigned Q_BITS     = 16,
    parameter int unsigned LENGTH     = 64,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned MAG_BITS   = mag_bits(I_BITS, Q_BITS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_axis_product_tvalid,
    input  logic signed [I_BITS-1:0]     i,
    input  logic signed [Q_BITS-1:0]     q,
    output logic                         m_axis_product_tready,
    output logic                         s_axis_peak_tvalid,
    input  logic                         m_axis_peak_tready,
    output logic        [INDEX_BITS-1:0] peak_index,
    output logic        [MAG_BITS-1:0]   peak_mag
);

    localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(LENGTH - 1);

    caf_state_e state_q;
    caf_state_e state_d;

    logic                  accept_c;
    logic                  last_c;
    logic                  latch_c;
    logic                  clear_c;
    logic [INDEX_BITS-1:0] accept_cnt;

    logic                  mid_valid;
    logic                  mag_valid;
    logic [INDEX_BITS-1:0] mag_index;
    logic [MAG_BITS-1:0]   mag;

    logic [INDEX_BITS-1:0] max_index;
    logic [MAG_BITS-1:0]   max_mag;

    assign accept_c = s_axis_product_tvalid && m_axis_product_tready;
    assign last_c   = (accept_cnt == LAST_INDEX);

    cplx_mag_sq #(
        .I_BITS     (I_BITS),
        .Q_BITS     (Q_BITS),
        .INDEX_BITS (INDEX_BITS),
        .MAG_BITS   (MAG_BITS)
    ) u_mag (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept_c),
        .i         (i),
        .q         (q),
        .in_index  (accept_cnt),
        .mid_valid (mid_valid),
        .out_valid (mag_valid),
        .out_index (mag_index),
        .out_mag   (mag)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_d = state_q;
        latch_c = 1'b0;
        clear_c = 1'b0;
        case (state_q)
            ACCUM: begin
                if (accept_c && last_c) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!mid_valid && !mag_valid) begin
                    state_d = HOLD;
                    latch_c = 1'b1;
                end
            end
            HOLD: begin
                if (m_axis_peak_tready) begin
                    state_d = ACCUM;
                    clear_c = 1'b1;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they track it without comb paths.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_axis_product_tready <= 1'b0;
            s_axis_peak_tvalid    <= 1'b0;
        end else begin
            m_axis_product_tready <= (state_d == ACCUM);
            s_axis_peak_tvalid    <= (state_d == HOLD);
        end
    end

    // Accept counter; wraps on the final product of the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accept_cnt <= '0;
        end else if (accept_c) begin
            accept_cnt <= last_c ? '0 : accept_cnt + INDEX_BITS'(1);
        end
    end

    // Running maximum: strict compare keeps the earliest index on ties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_index <= '0;
            max_mag   <= '0;
        end else if (clear_c) begin
            max_index <= '0;
            max_mag   <= '0;
        end else if (mag_valid && ((mag_index == '0) || (mag > max_mag))) begin
            max_index <= mag_index;
            max_mag   <= mag;
        end
    end

    // Result registers hold steady for the whole HOLD interval.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_index <= '0;
            peak_mag   <= '0;
        end else if (latch_c) begin
            peak_index <= max_index;
            peak_mag   <= max_mag;
        end
    end

endmodule

// File: tb/tb_caf_peak_finder.sv
// Directed bench for caf_peak_finder with I_BITS=Q_BITS=8, LENGTH=8.
module tb_caf_peak_finder;

    localparam int unsigned I_BITS     = 8;
    localparam int unsigned Q_BITS     = 8;
    localparam int unsigned LENGTH     = 8;
    localparam int unsigned INDEX_BITS = 3;
    localparam int unsigned MAG_BITS   = 16;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         s_axis_product_tvalid;
    logic signed [I_BITS-1:0]     i;
    logic signed [Q_BITS-1:0]     q;
    logic                         m_axis_product_tready;
    logic                         s_axis_peak_tvalid;
    logic                         m_axis_peak_tready;
    logic        [INDEX_BITS-1:0] peak_index;
    logic        [MAG_BITS-1:0]   peak_mag;

    int checks   = 0;
    int failures = 0;
    int fi[8];
    int fq[8];

    caf_peak_finder #(
        .I_BITS     (I_BITS),
        .Q_BITS     (Q_BITS),
        .LENGTH     (LENGTH),
        .INDEX_BITS (INDEX_BITS),
        .MAG_BITS   (MAG_BITS)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .s_axis_product_tvalid (s_axis_product_tvalid),
        .i                     (i),
        .q                     (q),
        .m_axis_product_tready (m_axis_product_tready),
        .s_axis_peak_tvalid    (s_axis_peak_tvalid),
        .m_axis_peak_tready    (m_axis_peak_tready),
        .peak_index            (peak_index),
        .peak_mag              (peak_mag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int bi, input int bq);
        for (int k = 0; k < 8; k++) begin
            fi[k] = bi;
            fq[k] = bq;
        end
    endtask

    // Streams fi/fq as one frame, optionally with idle cycles between accepts.
    task automatic run_frame(input string tag, input bit gapped, input int exp_idx, input int exp_mag);
        int k;
        int n;
        int lat;
        k = 0;
        n = 0;
        check({tag, "_ready_start"}, 32'(m_axis_product_tready), 32'd1);
        while (k < 8 && n < 40) begin
            if (gapped && (n % 2 == 1)) begin
                s_axis_product_tvalid = 1'b0;
                i = 8'sd100;
                q = -8'sd100;
            end else begin
                s_axis_product_tvalid = 1'b1;
                i = 8'(fi[k]);
                q = 8'(fq[k]);
                k++;
            end
            n++;
            step();
        end
        s_axis_product_tvalid = 1'b0;
        i = 8'sd99;
        q = 8'sd99;
        check({tag, "_ready_low"}, 32'(m_axis_product_tready), 32'd0);
        lat = 0;
        while (!s_axis_peak_tvalid && lat < 10) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_index"}, 32'(peak_index), 32'(exp_idx));
        check({tag, "_mag"}, 32'(peak_mag), 32'(exp_mag));
    endtask

    task automatic handshake(input string tag);
        m_axis_peak_tready = 1'b1;
        step();
        m_axis_peak_tready = 1'b0;
        check({tag, "_tvalid_drop"}, 32'(s_axis_peak_tvalid), 32'd0);
        check({tag, "_ready_back"}, 32'(m_axis_product_tready), 32'd1);
    endtask

    initial begin
        logic [INDEX_BITS-1:0] held_idx;
        logic [MAG_BITS-1:0]   held_mag;

        reset = 1'b1;
        s_axis_product_tvalid = 1'b0;
        i = '0;
        q = '0;
        m_axis_peak_tready = 1'b0;
        repeat (3) step();
        check("rst_ready", 32'(m_axis_product_tready), 32'd0);
        check("rst_tvalid", 32'(s_axis_peak_tvalid), 32'd0);
        check("rst_index", 32'(peak_index), 32'd0);
        check("rst_mag", 32'(peak_mag), 32'd0);
        reset = 1'b0;
        #2;
        check("rel_ready_before_edge", 32'(m_axis_product_tready), 32'd0);
        step();
        check("rel_ready_after_edge", 32'(m_axis_product_tready), 32'd1);

        // Single peak at index 5.
        fill(1, 1);
        fi[5] = 3;
        fq[5] = 4;
        run_frame("single", 1'b0, 5, 25);
        handshake("single_hs");

        // Tie keeps the earliest index.
        fill(0, 0);
        fi[2] = 5; fq[2] = 5;
        fi[6] = 5; fq[6] = 5;
        run_frame("tie", 1'b0, 2, 50);
        handshake("tie_hs");

        // Full negative scale on both rails.
        fill(127, 127);
        fi[0] = -128;
        fq[0] = -128;
        run_frame("extreme", 1'b0, 0, 32768);

        // Backpressure: result and handshake flags stay frozen.
        held_idx = peak_index;
        held_mag = peak_mag;
        s_axis_product_tvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp_tvalid", 32'(s_axis_peak_tvalid), 32'd1);
            check("bp_index", 32'(peak_index), 32'(held_idx));
            check("bp_mag", 32'(peak_mag), 32'(held_mag));
            check("bp_ready", 32'(m_axis_product_tready), 32'd0);
        end
        s_axis_product_tvalid = 1'b0;
        handshake("bp_hs");

        // Gapped input: idle cycles carry large garbage that must not count.
        fill(0, 0);
        fi[7] = 2;
        run_frame("gapped", 1'b1, 7, 4);
        handshake("gapped_hs");

        // Leave a nonzero result latched, then reset mid-frame.
        fill(0, 0);
        fi[6] = 9;
        run_frame("prefill", 1'b0, 6, 81);
        handshake("prefill_hs");
        s_axis_product_tvalid = 1'b1;
        i = 8'sd50;
        q = 8'sd50;
        repeat (4) step();
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(m_axis_product_tready), 32'd0);
        check("mid_rst_tvalid", 32'(s_axis_peak_tvalid), 32'd0);
        check("mid_rst_index", 32'(peak_index), 32'd0);
        check("mid_rst_mag", 32'(peak_mag), 32'd0);
        s_axis_product_tvalid = 1'b0;
        step();
        reset = 1'b0;
        step();
        fill(0, 0);
        fi[1] = 3;
        fq[1] = 4;
        run_frame("post_rst", 1'b0, 1, 25);
        handshake("post_rst_hs");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
